buffer_write_multi_flow: RTL and testbench

//  Write-side front end of the shared segmented packet buffer. Accepts AXI-Stream packets tagged with a flow ID.
//  For each packet it takes segments from a free-segment list and writes every beat to {segment, offset} in the buffer RAM.
//  It publishes each filled segment as a used pointer (with a tlast flag) to the per-flow lists of the read side.
//  It returns segments freed by the read side to the free list.

---
 rtl/buffer_pkg.sv | 27 ++
 rtl/buffer_write_multi_flow_pointers.sv | 88 ++++++++
 rtl/buffer_write_multi_flow.sv | 199 +++++++++++++++++++
 tb/tb_buffer_write_multi_flow.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/buffer_pkg.sv
// Shared types for the segmented packet buffer write path.
// Default widths; the write front end re-derives them from its parameters.
package buffer_pkg;

    localparam int DEF_SEGMENT_SIZE_W = 10;
    localparam int DEF_BUF_SEG_AW     = 10;
    localparam int DEF_ADDR_WIDTH     = DEF_BUF_SEG_AW + DEF_SEGMENT_SIZE_W;
    localparam int DEF_FLOWS_W        = 3;
    localparam int DEF_DATA_W         = 64;

    typedef logic [DEF_BUF_SEG_AW-1:0] seg_t;

    typedef struct packed {
        logic tlast;
        seg_t seg;
    } used_ptr_t;

    typedef logic [DEF_FLOWS_W-1:0]    flow_t;
    typedef logic [DEF_ADDR_WIDTH-1:0] addr_t;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        SOP  = 2'd1,
        MOP  = 2'd2
    } wr_state_t;

endpackage

// File: rtl/buffer_write_multi_flow_pointers.sv
// Free-segment pointer FIFO; optionally self-loads 0..2**DATA_W-1 after reset.
// Read data is registered and valid the cycle after rd_req.
module buffer_write_multi_flow_pointers
    import buffer_pkg::*;
#(
    parameter int DATA_W              = 10,
    parameter     INITIALISE_POINTERS = "YES"
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en,
    input  logic              rd_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              fifo_empty,
    output logic              init_done
);

    localparam int  DEPTH   = 2 ** DATA_W;
    localparam bit  INIT_EN = (INITIALISE_POINTERS == "YES");
    localparam logic [DATA_W:0]   CNT_ONE  = (DATA_W+1)'(1);
    localparam logic [DATA_W:0]   CNT_FULL = (DATA_W+1)'(DEPTH);
    localparam logic [DATA_W-1:0] PTR_ONE  = DATA_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              init_done_q;
    logic [DATA_W-1:0] init_cnt_q;
    logic [DATA_W-1:0] wr_ptr_q;
    logic [DATA_W-1:0] rd_ptr_q;
    logic [DATA_W:0]   count_q;
    logic [DATA_W-1:0] rd_data_q;

    logic              mem_we;
    logic [DATA_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;
    logic              fifo_full;

    assign fifo_full  = count_q[DATA_W];
    assign fifo_empty = !init_done_q || (count_q == '0);
    assign init_done  = init_done_q;
    assign rd_data    = rd_data_q;

    // The init sweep owns the write port until the list is full.
    assign mem_we = !init_done_q || wr_en;
    assign mem_wa = init_done_q ? wr_ptr_q : init_cnt_q;
    assign mem_wd = init_done_q ? wr_data  : init_cnt_q;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            init_done_q <= !INIT_EN;
            init_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_data_q   <= '0;
        end else if (!init_done_q) begin
            init_cnt_q <= init_cnt_q + PTR_ONE;
            if (&init_cnt_q) begin
                init_done_q <= 1'b1;
                count_q     <= CNT_FULL;
            end
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (rd_req) begin
                rd_ptr_q  <= rd_ptr_q + PTR_ONE;
                rd_data_q <= mem[rd_ptr_q];
            end
            unique case ({wr_en, rd_req})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    a_no_write_full: assert property (@(posedge clk) disable iff (!rstn)
        !(wr_en && fifo_full && init_done_q));

endmodule

// File: rtl/buffer_write_multi_flow.sv
// Write-side front end of the segmented packet buffer (flow-tagged AXI-Stream in).
// Optional free_count output under `BUF_WR_FREE_COUNT_EN.
module buffer_write_multi_flow
    import buffer_pkg::*;
#(
    parameter int SEGMENT_SIZE_W = 10,
    parameter int BUF_SEG_AW     = 10,
    parameter int ADDR_WIDTH     = BUF_SEG_AW + SEGMENT_SIZE_W,
    parameter int FLOWS_W        = 3,
    parameter int DATA_W         = 64
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic [DATA_W-1:0]     s_tdata,
    input  logic                  s_tlast,
    input  logic [FLOWS_W-1:0]    s_tflow,
    output logic                  b_wen,
    output logic [ADDR_WIDTH-1:0] b_waddr,
    output logic [DATA_W-1:0]     b_wdata,
    output logic [BUF_SEG_AW:0]   used_pointer,
    output logic                  used_pointer_valid,
    output logic [FLOWS_W-1:0]    used_pointer_flow,
    input  logic [BUF_SEG_AW-1:0] freed_pointer,
    input  logic                  freed_pointer_valid,
    output logic                  init_done
`ifdef BUF_WR_FREE_COUNT_EN
    ,
    output logic [BUF_SEG_AW:0]   free_count
`endif
);

    localparam logic [SEGMENT_SIZE_W-1:0] OFF_ONE = SEGMENT_SIZE_W'(1);

    wr_state_t                 state_q, state_d;
    logic [SEGMENT_SIZE_W-1:0] offset_q, offset_d;
    logic [BUF_SEG_AW-1:0]     cur_seg_q, cur_seg_d;
    logic [BUF_SEG_AW-1:0]     nxt_seg_q, nxt_seg_d;
    logic                      cur_v_q, cur_v_d;
    logic                      nxt_v_q, nxt_v_d;
    logic                      rd_pend_q;
    logic [FLOWS_W-1:0]        flow_q, flow_d;

    logic                      b_wen_q;
    logic [ADDR_WIDTH-1:0]     b_waddr_q;
    logic [DATA_W-1:0]         b_wdata_q;
    logic [BUF_SEG_AW:0]       up_q;
    logic                      up_valid_q;
    logic [FLOWS_W-1:0]        up_flow_q;

    logic                      rd_req;
    logic [BUF_SEG_AW-1:0]     rd_data;
    logic                      fifo_empty;
    logic                      acc;
    logic                      close;
    logic [FLOWS_W-1:0]        cur_flow;

    buffer_write_multi_flow_pointers #(
        .DATA_W              (BUF_SEG_AW),
        .INITIALISE_POINTERS ("YES")
    ) u_free_list (
        .clk        (clk),
        .rstn       (rstn),
        .wr_data    (freed_pointer),
        .wr_en      (freed_pointer_valid),
        .rd_req     (rd_req),
        .rd_data    (rd_data),
        .fifo_empty (fifo_empty),
        .init_done  (init_done)
    );

    assign s_tready = init_done && cur_v_q;
    assign acc      = s_tvalid && s_tready;
    assign close    = acc && (s_tlast || (&offset_q));
    assign rd_req   = (!cur_v_q || !nxt_v_q) && !rd_pend_q && !fifo_empty;
    assign cur_flow = (state_q == SOP) ? s_tflow : flow_q;

    // Close shifts nxt into cur first; a fetch landing on the same edge then
    // fills whichever slot is left empty.
    always_comb begin
        cur_seg_d = cur_seg_q;
        cur_v_d   = cur_v_q;
        nxt_seg_d = nxt_seg_q;
        nxt_v_d   = nxt_v_q;
        if (close) begin
            cur_seg_d = nxt_seg_q;
            cur_v_d   = nxt_v_q;
            nxt_v_d   = 1'b0;
        end
        if (rd_pend_q) begin
            if (!cur_v_d) begin
                cur_seg_d = rd_data;
                cur_v_d   = 1'b1;
            end else begin
                nxt_seg_d = rd_data;
                nxt_v_d   = 1'b1;
            end
        end
    end

    always_comb begin
        offset_d = offset_q;
        if (close) begin
            offset_d = '0;
        end else if (acc) begin
            offset_d = offset_q + OFF_ONE;
        end
    end

    always_comb begin
        state_d = state_q;
        flow_d  = flow_q;
        unique case (state_q)
            INIT: if (init_done) state_d = SOP;
            SOP: begin
                if (acc) begin
                    flow_d  = s_tflow;
                    state_d = s_tlast ? SOP : MOP;
                end
            end
            MOP: if (acc && s_tlast) state_d = SOP;
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= INIT;
            offset_q   <= '0;
            cur_seg_q  <= '0;
            cur_v_q    <= 1'b0;
            nxt_seg_q  <= '0;
            nxt_v_q    <= 1'b0;
            rd_pend_q  <= 1'b0;
            flow_q     <= '0;
            b_wen_q    <= 1'b0;
            b_waddr_q  <= '0;
            b_wdata_q  <= '0;
            up_q       <= '0;
            up_valid_q <= 1'b0;
            up_flow_q  <= '0;
        end else begin
            state_q    <= state_d;
            offset_q   <= offset_d;
            cur_seg_q  <= cur_seg_d;
            cur_v_q    <= cur_v_d;
            nxt_seg_q  <= nxt_seg_d;
            nxt_v_q    <= nxt_v_d;
            rd_pend_q  <= rd_req;
            flow_q     <= flow_d;
            b_wen_q    <= acc;
            up_valid_q <= close;
            if (acc) begin
                b_waddr_q <= ADDR_WIDTH'({cur_seg_q, offset_q});
                b_wdata_q <= s_tdata;
            end
            if (close) begin
                up_q      <= {s_tlast, cur_seg_q};
                up_flow_q <= cur_flow;
            end
        end
    end

    assign b_wen              = b_wen_q;
    assign b_waddr            = b_waddr_q;
    assign b_wdata            = b_wdata_q;
    assign used_pointer       = up_q;
    assign used_pointer_valid = up_valid_q;
    assign used_pointer_flow  = up_flow_q;

`ifdef BUF_WR_FREE_COUNT_EN
    localparam logic [BUF_SEG_AW:0] FC_ALL = (BUF_SEG_AW+1)'(2 ** BUF_SEG_AW);
    localparam logic [BUF_SEG_AW:0] FC_ONE = (BUF_SEG_AW+1)'(1);

    logic [BUF_SEG_AW:0] free_cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            free_cnt_q <= FC_ALL;
        end else begin
            unique case ({rd_req, freed_pointer_valid})
                2'b10:   free_cnt_q <= free_cnt_q - FC_ONE;
                2'b01:   free_cnt_q <= free_cnt_q + FC_ONE;
                default: free_cnt_q <= free_cnt_q;
            endcase
        end
    end

    assign free_count = free_cnt_q;
`endif

    a_no_rd_empty: assert property (@(posedge clk) disable iff (!rstn)
        !(rd_req && fifo_empty));

    a_up_per_beat: assert property (@(posedge clk) disable iff (!rstn)
        used_pointer_valid |-> $past(acc));

endmodule

// File: tb/tb_buffer_write_multi_flow.sv
// Directed bench for buffer_write_multi_flow: 4 segments of 8 beats.
// Checks free_count too when built with BUF_WR_FREE_COUNT_EN.
module tb_buffer_write_multi_flow;

    localparam int SW  = 3;
    localparam int AW  = 2;
    localparam int FW  = 3;
    localparam int DW  = 64;
    localparam int ADW = AW + SW;

    logic           clk;
    logic           rstn;
    logic           s_tvalid;
    logic           s_tready;
    logic [DW-1:0]  s_tdata;
    logic           s_tlast;
    logic [FW-1:0]  s_tflow;
    logic           b_wen;
    logic [ADW-1:0] b_waddr;
    logic [DW-1:0]  b_wdata;
    logic [AW:0]    used_pointer;
    logic           used_pointer_valid;
    logic [FW-1:0]  used_pointer_flow;
    logic [AW-1:0]  freed_pointer;
    logic           freed_pointer_valid;
    logic           init_done;
`ifdef BUF_WR_FREE_COUNT_EN
    logic [AW:0]    free_count;
`endif

    int checks   = 0;
    int failures = 0;

    buffer_write_multi_flow #(
        .SEGMENT_SIZE_W (SW),
        .BUF_SEG_AW     (AW),
        .ADDR_WIDTH     (ADW),
        .FLOWS_W        (FW),
        .DATA_W         (DW)
    ) dut (
        .clk                 (clk),
        .rstn                (rstn),
        .s_tvalid            (s_tvalid),
        .s_tready            (s_tready),
        .s_tdata             (s_tdata),
        .s_tlast             (s_tlast),
        .s_tflow             (s_tflow),
        .b_wen               (b_wen),
        .b_waddr             (b_waddr),
        .b_wdata             (b_wdata),
        .used_pointer        (used_pointer),
        .used_pointer_valid  (used_pointer_valid),
        .used_pointer_flow   (used_pointer_flow),
        .freed_pointer       (freed_pointer),
        .freed_pointer_valid (freed_pointer_valid),
        .init_done           (init_done)
`ifdef BUF_WR_FREE_COUNT_EN
        ,
        .free_count          (free_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one beat at a negedge, wait (bounded) for ready, and return at the
    // negedge after acceptance. waited = -1 when ready never came.
    task automatic send_beat(input logic [DW-1:0] d, input logic last,
                             input logic [FW-1:0] fl, output int waited);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = last;
        s_tflow  = fl;
        waited   = 0;
        while (s_tready !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (s_tready !== 1'b1) begin
            waited   = -1;
            s_tvalid = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            s_tvalid = 1'b0;
        end
    endtask

    task automatic free_seg(input logic [AW-1:0] s);
        freed_pointer       = s;
        freed_pointer_valid = 1'b1;
        @(negedge clk);
        freed_pointer_valid = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({s_tready, b_wen, b_waddr, b_wdata, used_pointer, used_pointer_valid,
             used_pointer_flow, init_done} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: ready=%b wen=%b waddr=%h up=%h upv=%b init=%b, want all 0",
                     s_tready, b_wen, b_waddr, used_pointer, used_pointer_valid, init_done);
        end
        rstn = 1'b1;
        n = 0;
        while (init_done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (init_done !== 1'b1) begin
            failures++;
            $display("FAIL init_done: got %b after %0d cycles, want 1", init_done, n);
        end
        repeat (6) @(negedge clk);
`ifdef BUF_WR_FREE_COUNT_EN
        checks++;
        if (free_count !== 3'd2) begin
            failures++;
            $display("FAIL fc_after_prefetch: got %0d want 2", free_count);
        end
`endif
    endtask

    task automatic test_single_packet();
        int w;
        for (int i = 0; i < 3; i++) begin
            send_beat(64'hA000 + 64'(i), i == 2, 3'd5, w);
            checks++;
            if (w < 0 || b_wen !== 1'b1 || b_waddr !== {2'd0, 3'(i)} ||
                b_wdata !== 64'hA000 + 64'(i)) begin
                failures++;
                $display("FAIL t1_beat%0d: wait=%0d wen=%b waddr=%h wdata=%h, want waddr=%h",
                         i, w, b_wen, b_waddr, b_wdata, {2'd0, 3'(i)});
            end
            checks++;
            if (used_pointer_valid !== (i == 2)) begin
                failures++;
                $display("FAIL t1_upv%0d: got %b want %b", i, used_pointer_valid, i == 2);
            end
        end
        checks++;
        if (used_pointer !== 3'b100 || used_pointer_flow !== 3'd5) begin
            failures++;
            $display("FAIL t1_used: ptr=%b flow=%0d, want ptr=100 flow=5",
                     used_pointer, used_pointer_flow);
        end
        free_seg(2'd0);
    endtask

    task automatic test_multi_segment();
        int w;
        int bubbles;
        logic [AW-1:0] seg;
        logic cl;
        bubbles = 0;
        for (int i = 0; i < 20; i++) begin
            seg = (i < 8) ? 2'd1 : (i < 16) ? 2'd2 : 2'd3;
            cl  = (i == 7) || (i == 15) || (i == 19);
            send_beat(64'hB000 + 64'(i), i == 19, 3'd2, w);
            if (w != 0) bubbles++;
            checks++;
            if (w < 0 || b_wen !== 1'b1 || b_waddr !== {seg, 3'(i % 8)} ||
                b_wdata !== 64'hB000 + 64'(i) || used_pointer_valid !== cl) begin
                failures++;
                $display("FAIL t2_beat%0d: wait=%0d waddr=%h upv=%b, want waddr=%h upv=%b",
                         i, w, b_waddr, used_pointer_valid, {seg, 3'(i % 8)}, cl);
            end
            if (cl) begin
                checks++;
                if (used_pointer !== {i == 19, seg} || used_pointer_flow !== 3'd2) begin
                    failures++;
                    $display("FAIL t2_used%0d: ptr=%b flow=%0d, want ptr=%b flow=2",
                             i, used_pointer, used_pointer_flow, {i == 19, seg});
                end
            end
        end
        checks++;
        if (bubbles != 0) begin
            failures++;
            $display("FAIL t2_bubbles: got %0d want 0", bubbles);
        end
        free_seg(2'd1);
        free_seg(2'd2);
        free_seg(2'd3);
    endtask

    task automatic test_flow_change();
        int w;
        logic [AW-1:0] seg;
        logic cl;
        for (int i = 0; i < 10; i++) begin
            seg = (i < 8) ? 2'd0 : 2'd1;
            cl  = (i == 7) || (i == 9);
            send_beat(64'hC000 + 64'(i), i == 9, (i == 0) ? 3'd1 : 3'd6, w);
            checks++;
            if (w < 0 || b_waddr !== {seg, 3'(i % 8)} || used_pointer_valid !== cl) begin
                failures++;
                $display("FAIL t3_beat%0d: wait=%0d waddr=%h upv=%b, want waddr=%h upv=%b",
                         i, w, b_waddr, used_pointer_valid, {seg, 3'(i % 8)}, cl);
            end
            if (cl) begin
                checks++;
                if (used_pointer !== {i == 9, seg} || used_pointer_flow !== 3'd1) begin
                    failures++;
                    $display("FAIL t3_used%0d: ptr=%b flow=%0d, want ptr=%b flow=1",
                             i, used_pointer, used_pointer_flow, {i == 9, seg});
                end
            end
        end
        free_seg(2'd0);
        free_seg(2'd1);
`ifdef BUF_WR_FREE_COUNT_EN
        checks++;
        if (free_count !== 3'd2) begin
            failures++;
            $display("FAIL t3_fc: got %0d want 2", free_count);
        end
`endif
    endtask

    task automatic test_free_list_empty();
        int w;
        int stalled;
        logic [AW-1:0] segs [4];
        segs = '{2'd2, 2'd3, 2'd0, 2'd1};
        for (int i = 0; i < 4; i++) begin
            send_beat(64'hD000 + 64'(i), 1'b1, 3'(i + 4), w);
            checks++;
            if (w < 0 || b_waddr !== {segs[i], 3'd0} || used_pointer_valid !== 1'b1 ||
                used_pointer !== {1'b1, segs[i]} || used_pointer_flow !== 3'(i + 4)) begin
                failures++;
                $display("FAIL t4_pkt%0d: wait=%0d waddr=%h up=%b flow=%0d, want seg=%0d",
                         i, w, b_waddr, used_pointer, used_pointer_flow, segs[i]);
            end
        end
        s_tvalid = 1'b1;
        s_tdata  = 64'hD004;
        s_tlast  = 1'b1;
        s_tflow  = 3'd7;
        stalled  = 0;
        for (int i = 0; i < 3; i++) begin
            if (s_tready === 1'b0) stalled++;
            @(negedge clk);
        end
        checks++;
        if (stalled != 3) begin
            failures++;
            $display("FAIL t4_stall: ready low %0d of 3 cycles, want 3", stalled);
        end
`ifdef BUF_WR_FREE_COUNT_EN
        checks++;
        if (free_count !== 3'd0) begin
            failures++;
            $display("FAIL t4_fc_empty: got %0d want 0", free_count);
        end
`endif
        free_seg(2'd2);
        checks++;
        if (s_tready !== 1'b0) begin
            failures++;
            $display("FAIL t4_ready_c1: got %b want 0", s_tready);
        end
`ifdef BUF_WR_FREE_COUNT_EN
        checks++;
        if (free_count !== 3'd1) begin
            failures++;
            $display("FAIL t4_fc_c1: got %0d want 1", free_count);
        end
`endif
        @(negedge clk);
        checks++;
        if (s_tready !== 1'b0) begin
            failures++;
            $display("FAIL t4_ready_c2: got %b want 0", s_tready);
        end
`ifdef BUF_WR_FREE_COUNT_EN
        checks++;
        if (free_count !== 3'd0) begin
            failures++;
            $display("FAIL t4_fc_c2: got %0d want 0", free_count);
        end
`endif
        @(negedge clk);
        checks++;
        if (s_tready !== 1'b1) begin
            failures++;
            $display("FAIL t4_ready_c3: got %b want 1", s_tready);
        end
        send_beat(64'hD004, 1'b1, 3'd7, w);
        checks++;
        if (w != 0 || b_waddr !== 5'b10_000 || b_wdata !== 64'hD004 ||
            used_pointer !== 3'b110 || used_pointer_flow !== 3'd7) begin
            failures++;
            $display("FAIL t4_resume: wait=%0d waddr=%h up=%b flow=%0d, want waddr=10 up=110 flow=7",
                     w, b_waddr, used_pointer, used_pointer_flow);
        end
        free_seg(2'd3);
        free_seg(2'd0);
        free_seg(2'd1);
        free_seg(2'd2);
    endtask

    task automatic test_reset_mid_packet();
        int w;
        int n;
        int stray;
        for (int i = 0; i < 3; i++) begin
            send_beat(64'hE000 + 64'(i), 1'b0, 3'd3, w);
            checks++;
            if (w < 0 || b_wen !== 1'b1 || b_waddr !== {2'd3, 3'(i)}) begin
                failures++;
                $display("FAIL t5_beat%0d: wait=%0d wen=%b waddr=%h, want waddr=%h",
                         i, w, b_wen, b_waddr, {2'd3, 3'(i)});
            end
        end
        s_tvalid = 1'b1;
        s_tdata  = 64'hE003;
        s_tlast  = 1'b0;
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({s_tready, b_wen, b_waddr, b_wdata, used_pointer, used_pointer_valid,
             used_pointer_flow, init_done} !== '0) begin
            failures++;
            $display("FAIL t5_abort_outputs: ready=%b wen=%b waddr=%h wdata=%h up=%h init=%b, want all 0",
                     s_tready, b_wen, b_waddr, b_wdata, used_pointer, init_done);
        end
        s_tvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        n = 0;
        while (init_done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (init_done !== 1'b1) begin
            failures++;
            $display("FAIL t5_init_done: got %b want 1", init_done);
        end
`ifdef BUF_WR_FREE_COUNT_EN
        checks++;
        if (free_count !== 3'd4) begin
            failures++;
            $display("FAIL t5_fc_reset: got %0d want 4", free_count);
        end
`endif
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            if (used_pointer_valid !== 1'b0 || b_wen !== 1'b0) stray++;
            @(negedge clk);
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL t5_no_stray: %0d cycles with upv/wen set, want 0", stray);
        end
    endtask

    task automatic test_free_and_fetch();
        int w;
        logic [AW-1:0] segs [4];
        segs = '{2'd1, 2'd2, 2'd3, 2'd0};
        send_beat(64'hF000, 1'b1, 3'd6, w);
        checks++;
        if (w < 0 || b_waddr !== 5'b00_000 || used_pointer !== 3'b100 ||
            used_pointer_flow !== 3'd6) begin
            failures++;
            $display("FAIL t6_first: wait=%0d waddr=%h up=%b flow=%0d, want waddr=00 up=100 flow=6",
                     w, b_waddr, used_pointer, used_pointer_flow);
        end
`ifdef BUF_WR_FREE_COUNT_EN
        checks++;
        if (free_count !== 3'd2) begin
            failures++;
            $display("FAIL t6_fc_before: got %0d want 2", free_count);
        end
`endif
        free_seg(2'd0);
`ifdef BUF_WR_FREE_COUNT_EN
        checks++;
        if (free_count !== 3'd2) begin
            failures++;
            $display("FAIL t6_fc_same_cycle: got %0d want 2", free_count);
        end
`endif
        for (int i = 0; i < 4; i++) begin
            send_beat(64'hF100 + 64'(i), 1'b1, 3'd0, w);
            checks++;
            if (w < 0 || b_waddr !== {segs[i], 3'd0} || used_pointer !== {1'b1, segs[i]}) begin
                failures++;
                $display("FAIL t6_pkt%0d: wait=%0d waddr=%h up=%b, want seg=%0d",
                         i, w, b_waddr, used_pointer, segs[i]);
            end
        end
    endtask

    initial begin
        rstn                = 1'b0;
        s_tvalid            = 1'b0;
        s_tdata             = '0;
        s_tlast             = 1'b0;
        s_tflow             = '0;
        freed_pointer       = '0;
        freed_pointer_valid = 1'b0;
        test_reset();
        test_single_packet();
        test_multi_segment();
        test_flow_change();
        test_free_list_empty();
        test_reset_mid_packet();
        test_free_and_fetch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
